// File: rtl/aes_dec_sched.sv
// aes_dec_sched: round-robin scheduler sharing one iterative AES decipher core between two requesters
// Ports:
//   clk, decReset            clock and synchronous active-high reset
//   req0_*/req1_*            valid/ready request ports carrying ciphertext and key
//   core_rst/core_in/core_key/core_out   drive and observe the shared decipher core
//   rsp_valid/rsp_ready/rsp_data/rsp_id  plaintext response tagged with the owning requester
//   busy                     high whenever a job is in flight (state != IDLE)
module aes_dec_sched #(
    parameter int Nk       = 4,
    parameter int CORE_LAT = Nk + 8
) (
    input  logic              clk,
    input  logic              decReset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [127:0]      req0_data,
    input  logic [Nk*32-1:0]  req0_key,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [127:0]      req1_data,
    input  logic [Nk*32-1:0]  req1_key,
    output logic              core_rst,
    output logic [127:0]      core_in,
    output logic [Nk*32-1:0]  core_key,
    input  logic [127:0]      core_out,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [127:0]      rsp_data,
    output logic              rsp_id,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, CLR, RUN, RESP} state_t;
    state_t           state_q;
    logic [4:0]       cnt_q;
    logic             rr_last_q;
    logic             job_id_q;
    logic [127:0]     job_data_q;
    logic [Nk*32-1:0] job_key_q;
    logic             can_acc;
    logic             gnt1;
    logic             accept;
    // readies are held low while reset is asserted, even if the FSM already sits in IDLE
    assign can_acc    = (state_q == IDLE) & ~decReset;
    // on a tie the requester that did not win last time is granted
    assign gnt1       = req1_valid & (~req0_valid | ~rr_last_q);
    assign accept     = can_acc & (req0_valid | req1_valid);
    assign req0_ready = accept & ~gnt1;
    assign req1_ready = can_acc & gnt1;
    assign core_rst   = decReset | (state_q == CLR);
    assign core_in    = job_data_q;
    assign core_key   = job_key_q;
    assign busy       = state_q != IDLE;
    always_ff @(posedge clk) begin
        if (decReset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rr_last_q <= 1'b1;
            job_id_q  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    job_data_q <= gnt1 ? req1_data : req0_data;
                    job_key_q  <= gnt1 ? req1_key : req0_key;
                    job_id_q   <= gnt1;
                    rr_last_q  <= gnt1;
                    state_q    <= CLR;
                end
                CLR: begin
                    cnt_q   <= '0;
                    state_q <= RUN;
                end
                RUN: begin
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'(CORE_LAT - 1)) begin
                        rsp_data  <= core_out;
                        rsp_id    <= job_id_q;
                        rsp_valid <= 1'b1;
                        state_q   <= RESP;
                    end
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
